// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port data memory,
// with locked bursts capped for fairness and 1-cycle registered read responses.
module dmem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 32,
    parameter int MAX_BURST   = 8,
    parameter int P0_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        busy_owner
);
    typedef enum logic [1:0] {OPEN = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_rr, w_rr_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic              r_rv0, r_rv1;
    logic [DATA_W-1:0] r_rd0, r_rd1;
    logic              w_g0, w_g1, w_own1, w_own_lock, w_other_req, w_rd0, w_rd1;

    assign w_own1      = r_state == OWN1;
    assign w_own_lock  = w_own1 ? p1_lock : p0_lock;
    assign w_other_req = w_own1 ? p0_req : p1_req;

    // r_rr = 1 means port 1 is preferred in open arbitration; r_cnt counts granted beats
    always_comb begin
        w_g0        = 1'b0;
        w_g1        = 1'b0;
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_cnt_nxt   = r_cnt;
        if (!Reset && r_state == OPEN) begin
            w_g1 = p1_req && (!p0_req || (P0_PRIORITY == 0 && r_rr));
            w_g0 = p0_req && !w_g1;
            if (w_g0 || w_g1) begin
                w_rr_nxt = w_g0;
                if (w_g0 ? p0_lock : p1_lock) begin
                    w_state_nxt = w_g0 ? OWN0 : OWN1;
                    w_cnt_nxt   = 8'd1;
                end
            end
        end else if (!Reset) begin
            w_g0 = !w_own1 && p0_req;
            w_g1 = w_own1 && p1_req;
            // the beat that completes MAX_BURST grants while the other port waits is the last one
            if (w_g0 || w_g1) begin
                if (!w_own_lock || (w_other_req && r_cnt >= 8'(MAX_BURST - 1))) begin
                    w_state_nxt = OPEN;
                    w_cnt_nxt   = '0;
                    w_rr_nxt    = !w_own1;
                end else if (r_cnt < 8'(MAX_BURST)) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
        end
    end

    assign p0_gnt     = w_g0;
    assign p1_gnt     = w_g1;
    assign mem_addr   = w_g0 ? p0_addr : (w_g1 ? p1_addr : '0);
    assign mem_wdata  = w_g0 ? p0_wdata : (w_g1 ? p1_wdata : '0);
    assign mem_write  = (w_g0 && p0_we) || (w_g1 && p1_we);
    assign w_rd0      = w_g0 && !p0_we;
    assign w_rd1      = w_g1 && !p1_we;
    assign mem_read   = w_rd0 || w_rd1;
    assign busy_owner = r_state;
    assign p0_rvalid  = r_rv0;
    assign p1_rvalid  = r_rv1;
    assign p0_rdata   = r_rd0;
    assign p1_rdata   = r_rd1;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= OPEN;
            r_rr    <= 1'b0;
            r_cnt   <= '0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rv0   <= w_rd0;
            r_rv1   <= w_rd1;
            if (w_rd0) r_rd0 <= mem_rdata;
            if (w_rd1) r_rd1 <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a queue-based scoreboard for dmem_arbiter,
// plus a second instance in fixed-priority mode.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset;
    logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
    logic [63:0] p0_addr, p1_addr, mem_addr;
    logic [31:0] p0_wdata, p1_wdata, mem_wdata, mem_rdata, p0_rdata, p1_rdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_write, mem_read;
    logic [1:0]  busy_owner;

    logic        q_g0, q_g1, q_rv0, q_rv1, q_mw, q_mr;
    logic [31:0] q_rd0, q_rd1, q_md;
    logic [63:0] q_ma;
    logic [1:0]  q_own;

    dmem_arbiter u_dut (
        .clk(clk), .Reset(Reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .busy_owner(busy_owner)
    );

    dmem_arbiter #(.P0_PRIORITY(1)) u_pri (
        .clk(clk), .Reset(Reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(q_g0), .p0_rvalid(q_rv0), .p0_rdata(q_rd0),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(q_g1), .p1_rvalid(q_rv1), .p1_rdata(q_rd1),
        .mem_addr(q_ma), .mem_wdata(q_md), .mem_write(q_mw), .mem_read(q_mr),
        .mem_rdata(32'h0), .busy_owner(q_own)
    );

    function automatic logic [31:0] init_word(input logic [9:0] i);
        return (i == 10'd4) ? 32'hDEADBEEF : (32'hC0DE0000 ^ {22'h0, i});
    endfunction

    // memory environment: unwritten words read back their initial pattern
    logic [31:0] mem [0:1023];
    bit   [1023:0] wr;
    always @(posedge clk) if (mem_write) begin
        mem[mem_addr[11:2]] <= mem_wdata;
        wr[mem_addr[11:2]]  <= 1'b1;
    end
    assign mem_rdata = !mem_read ? 32'h0 : (wr[mem_addr[11:2]] ? mem[mem_addr[11:2]] : init_word(mem_addr[11:2]));

    logic [31:0] ref_mem [0:1023];
    bit   [1023:0] ref_wr;

    typedef struct {
        logic        g0, g1, mr, mw, rv0, rv1, pri;
        logic [1:0]  own, pg;
        logic [63:0] ma;
        logic [31:0] md;
    } cyc_t;
    typedef struct {
        logic        port;
        logic [31:0] data;
    } rd_t;
    cyc_t exp_q[$];
    rd_t  rd_q[$];

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endfunction

    logic        s_rst, s0_req, s0_we, s0_lock, s1_req, s1_we, s1_lock;
    logic [63:0] s0_addr, s1_addr;
    logic [31:0] s0_wdata, s1_wdata;
    logic        pend0 = 1'b0, pend1 = 1'b0, pri_on = 1'b0;
    logic [1:0]  pri_exp = 2'b00;

    task automatic set0(input logic r, w, l, input logic [63:0] a, input logic [31:0] d);
        s0_req = r; s0_we = w; s0_lock = l; s0_addr = a; s0_wdata = d;
    endtask
    task automatic set1(input logic r, w, l, input logic [63:0] a, input logic [31:0] d);
        s1_req = r; s1_we = w; s1_lock = l; s1_addr = a; s1_wdata = d;
    endtask

    // apply staged inputs for one cycle and queue the hand-computed expected response
    task automatic step(input logic eg0, eg1, input logic [1:0] own);
        cyc_t e;
        rd_t  r;
        logic we;
        logic [9:0] i;
        @(posedge clk);
        #1;
        Reset = s_rst;
        p0_req = s0_req; p0_we = s0_we; p0_lock = s0_lock; p0_addr = s0_addr; p0_wdata = s0_wdata;
        p1_req = s1_req; p1_we = s1_we; p1_lock = s1_lock; p1_addr = s1_addr; p1_wdata = s1_wdata;
        we = eg0 ? s0_we : s1_we;
        e.g0 = eg0; e.g1 = eg1; e.own = own; e.pri = pri_on; e.pg = pri_exp;
        e.ma = eg0 ? s0_addr : (eg1 ? s1_addr : 64'h0);
        e.md = eg0 ? s0_wdata : (eg1 ? s1_wdata : 32'h0);
        e.mw = (eg0 || eg1) && we;
        e.mr = (eg0 || eg1) && !we;
        e.rv0 = pend0; e.rv1 = pend1;
        pend0 = eg0 && !s0_we;
        pend1 = eg1 && !s1_we;
        i = e.ma[11:2];
        if (e.mr) begin
            r.port = eg1;
            r.data = ref_wr[i] ? ref_mem[i] : init_word(i);
            rd_q.push_back(r);
        end
        if (e.mw) begin
            ref_mem[i] = e.md;
            ref_wr[i]  = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        cyc_t e;
        rd_t  r;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("p0_gnt", p0_gnt, e.g0);
            chk("p1_gnt", p1_gnt, e.g1);
            chk("mem_read", mem_read, e.mr);
            chk("mem_write", mem_write, e.mw);
            chk("mem_addr", mem_addr, e.ma);
            chk("mem_wdata", mem_wdata, e.md);
            chk("busy_owner", busy_owner, e.own);
            chk("p0_rvalid", p0_rvalid, e.rv0);
            chk("p1_rvalid", p1_rvalid, e.rv1);
            if (e.pri) begin
                chk("pri_p0_gnt", q_g0, e.pg[0]);
                chk("pri_p1_gnt", q_g1, e.pg[1]);
            end
        end
        if (p0_rvalid === 1'b1 || p1_rvalid === 1'b1) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got rvalid p0=%0b p1=%0b expected none", p0_rvalid, p1_rvalid);
            end else begin
                r = rd_q.pop_front();
                chk("rd_port", p1_rvalid, r.port);
                chk("rd_data", p1_rvalid ? p1_rdata : p0_rdata, r.data);
            end
        end
    end

    initial begin
        Reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
        s_rst = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        step(0, 0, 2'd0);
        step(0, 0, 2'd0);
        s_rst = 1'b0;
        // single read of word 4
        set0(1, 0, 0, 64'h10, 0); step(1, 0, 2'd0);
        set0(0, 0, 0, 0, 0);      step(0, 0, 2'd0);
        // round-robin from reset
        s_rst = 1'b1; step(0, 0, 2'd0); s_rst = 1'b0;
        set0(1, 0, 0, 64'h20, 0);
        set1(1, 0, 0, 64'h30, 0);
        step(1, 0, 2'd0); step(0, 1, 2'd0); step(1, 0, 2'd0); step(0, 1, 2'd0);
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); step(0, 0, 2'd0);
        // write then read same address
        set1(1, 1, 0, 64'h40, 32'h12345678); step(0, 1, 2'd0);
        set1(0, 0, 0, 0, 0); set0(1, 0, 0, 64'h40, 0); step(1, 0, 2'd0);
        set0(0, 0, 0, 0, 0); step(0, 0, 2'd0);
        // locked burst of 12 writes from p1 with p0 waiting: 8 beats, p0 once, p1 again
        set1(1, 1, 1, 64'h100, 32'hA0000000); step(0, 1, 2'd0);
        set0(1, 0, 0, 64'h10, 0);
        for (int k = 1; k < 8; k++) begin
            set1(1, 1, 1, 64'h100 + 64'(4 * k), 32'hA0000000 + 32'(k));
            step(0, 1, 2'd2);
        end
        set1(1, 1, 1, 64'h120, 32'hA0000008); step(1, 0, 2'd0);
        step(0, 1, 2'd0);
        for (int k = 9; k < 12; k++) begin
            set1(1, 1, k != 11, 64'h100 + 64'(4 * k), 32'hA0000000 + 32'(k));
            step(0, 1, 2'd2);
        end
        set1(0, 0, 0, 0, 0); step(1, 0, 2'd0);
        set0(0, 0, 0, 0, 0); step(0, 0, 2'd0);
        set1(1, 0, 0, 64'h11C, 0); step(0, 1, 2'd0);
        set1(0, 0, 0, 0, 0); step(0, 0, 2'd0);
        // reset in the middle of a p0 locked burst
        set0(1, 1, 1, 64'h200, 32'h55); step(1, 0, 2'd0);
        set0(1, 0, 1, 64'h10, 0);       step(1, 0, 2'd1);
        s_rst = 1'b1; set1(1, 0, 0, 64'h14, 0); step(0, 0, 2'd1);
        s_rst = 1'b0; set0(0, 0, 0, 0, 0); step(0, 1, 2'd0);
        set1(0, 0, 0, 0, 0); step(0, 0, 2'd0);
        // fixed priority instance against the round-robin one
        s_rst = 1'b1; step(0, 0, 2'd0); s_rst = 1'b0;
        pri_on = 1'b1;
        set0(1, 0, 0, 64'h20, 0);
        set1(1, 0, 0, 64'h30, 0);
        pri_exp = 2'b01;
        step(1, 0, 2'd0); step(0, 1, 2'd0); step(1, 0, 2'd0);
        set0(0, 0, 0, 0, 0); pri_exp = 2'b10; step(0, 1, 2'd0);
        set1(0, 0, 0, 0, 0); pri_exp = 2'b00; step(0, 0, 2'd0);
        pri_on = 1'b0;
        step(0, 0, 2'd0);
        @(negedge clk);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
